// File: rtl/if_fetch_queue.sv
// Fetch front end: single-outstanding instruction-bus fetch feeding a DEPTH-entry in-order decode queue.
// Return or faulting accept reaches dec_valid one cycle later; PCs accepted only when IDLE with a free slot, decode stalls via dec_ready.
module if_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          fetch_pc,
    input  logic [ADDR_W-1:0]          fetch_paddr,
    input  logic                       fetch_miss,
    input  logic                       fetch_invalid,
    input  logic                       fetch_illegal,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    output logic                       bus_req,
    output logic [ADDR_W-1:0]          bus_addr,
    input  logic                       bus_gnt,
    input  logic                       bus_rvalid,
    input  logic [DATA_W-1:0]          bus_rdata,
    input  logic                       flush,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [ADDR_W-1:0]          dec_pc,
    output logic [DATA_W-1:0]          dec_inst,
    output logic [2:0]                 dec_except,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_DATA, DISCARD} state_t;

    state_t              state_q;
    logic                discard_q;
    logic                bus_req_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
    logic [DATA_W-1:0]   inst_mem [DEPTH];
    logic [2:0]          exc_mem  [DEPTH];

    logic [2:0]          acc_exc;
    logic                fault;
    logic                accept;
    logic                ret_enq;
    logic                enq;
    logic                deq;
    logic [ADDR_W-1:0]   enq_pc;
    logic [DATA_W-1:0]   enq_inst;
    logic [2:0]          enq_exc;

    // Misalignment is reported through the illegal flag.
    assign acc_exc = {fetch_illegal | (fetch_pc[1:0] != 2'b00), fetch_invalid, fetch_miss};
    assign fault   = |acc_exc;

    assign fetch_ready = ~rst & (state_q == IDLE) & (count_q < CNT_W'(DEPTH)) & ~flush;
    assign accept      = fetch_valid & fetch_ready;

    assign ret_enq  = (state_q == WAIT_DATA) & bus_rvalid & ~flush;
    assign enq      = ret_enq | (accept & fault);
    assign enq_pc   = ret_enq ? pc_q : fetch_pc;
    assign enq_inst = ret_enq ? bus_rdata : '0;
    assign enq_exc  = ret_enq ? 3'b000 : acc_exc;

    assign dec_valid  = (count_q != '0);
    assign deq        = dec_valid & dec_ready & ~flush;
    assign dec_pc     = pc_mem[rd_ptr_q];
    assign dec_inst   = inst_mem[rd_ptr_q];
    assign dec_except = exc_mem[rd_ptr_q];
    assign count      = count_q;
    assign bus_req    = bus_req_q;
    assign bus_addr   = bus_addr_q;

    // discard_q remembers a flush seen while still waiting for grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            discard_q  <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            pc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !fault) begin
                        pc_q       <= fetch_pc;
                        bus_addr_q <= fetch_paddr;
                        bus_req_q  <= 1'b1;
                        state_q    <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= (flush || discard_q) ? DISCARD : WAIT_DATA;
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (bus_rvalid) begin
                        state_q <= IDLE;
                    end else if (flush) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            if (enq && !deq) begin
                count_d = count_q + 1'b1;
            end else if (!enq && deq) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]   <= enq_pc;
            inst_mem[wr_ptr_q] <= enq_inst;
            exc_mem[wr_ptr_q]  <= enq_exc;
        end
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end placed between PC generation / I-MMU and decode.
- Accepts one translated fetch PC at a time and issues a single-outstanding request on the instruction bus.
- Buffers returned instructions, tagged with PC and fetch-exception flags, in a DEPTH-entry in-order queue.
- Presents the queue head to decode through a valid/ready handshake; flush discards buffered and in-flight fetches.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- ADDR_W, 32, PC / physical address width
- DATA_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_pc  in  ADDR_W  virtual PC offered for fetch
- fetch_paddr  in  ADDR_W  I-MMU physical address for fetch_pc
- fetch_miss  in  1  I-MMU TLB miss for fetch_pc
- fetch_invalid  in  1  I-MMU invalid-entry fault for fetch_pc
- fetch_illegal  in  1  I-MMU privilege/illegal-address fault for fetch_pc
- fetch_valid  in  1  fetch_pc and its MMU flags are valid
- fetch_ready  out  1  PC accepted this cycle when fetch_valid & fetch_ready
- bus_req  out  1  instruction bus request
- bus_addr  out  ADDR_W  request physical address, registered
- bus_gnt  in  1  request accepted by bus this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DATA_W  read data
- flush  in  1  pipeline flush / redirect
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode consumes head
- dec_pc  out  ADDR_W  head PC
- dec_inst  out  DATA_W  head instruction; 0 for faulting entries
- dec_except  out  3  head flags {illegal, invalid, miss}
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: state IDLE; rd/wr pointers 0; count 0; bus_req 0; bus_addr 0; dec_valid 0; fetch_ready 0 while rst is high.
- Fault classification at accept: fault = fetch_miss | fetch_invalid | fetch_illegal | (fetch_pc[1:0] != 0).
  - The misalignment condition ORs into the illegal flag.
- fetch_ready = (state == IDLE) & (count < DEPTH) & ~flush.
  - Enqueue and in-flight slots together never exceed DEPTH, so a return always has a free slot.
- States:
  - IDLE: on accept with fault, enqueue {fetch_pc, inst = 0, flags} directly; stay IDLE; no bus request. On accept without fault, latch fetch_pc, flags and fetch_paddr; go to WAIT_GNT.
  - WAIT_GNT: bus_req = 1; bus_addr stays stable. On bus_gnt, go to WAIT_DATA. A request is never withdrawn before grant.
  - WAIT_DATA: bus_req = 0. On bus_rvalid, enqueue {latched PC, bus_rdata, 0} and go to IDLE. bus_rvalid is ignored in every other state. The bus never returns data in the grant cycle.
  - DISCARD: on bus_rvalid, drop the data and go to IDLE.
- Flush:
  - Pointers and count go to 0 next cycle; dec_valid goes to 0 next cycle.
  - Flush in IDLE: no state change. A PC offered in the flush cycle is not accepted.
  - Flush in WAIT_GNT: keep bus_req asserted. On bus_gnt go to DISCARD; if bus_gnt arrives in the flush cycle itself, go directly to DISCARD.
  - Flush in WAIT_DATA: go to DISCARD. If bus_rvalid is in the same cycle, drop the data and go to IDLE.
  - Flush in DISCARD: no effect beyond clearing the queue.
- Flush beats enqueue and dequeue in the same cycle.
- Dequeue when dec_valid & dec_ready. Simultaneous enqueue and dequeue leaves count unchanged.
- Pointers wrap modulo DEPTH.
- dec_valid = (count != 0); dec_pc, dec_inst and dec_except are read combinationally from the entry at rd_ptr.
- Latency:
  - bus_rvalid at cycle t gives dec_valid at t+1.
  - Faulting accept at t gives dec_valid at t+1.
  - Non-faulting accept at t gives bus_req at t+1.

Test Plan:
- Aligned PC 0x0000_1000, no fault, bus_gnt in the first request cycle, rvalid 2 cycles later with data 0x2402_0005, dec_ready = 1 -> exactly one bus request to paddr 0x0000_1000; dec_valid one cycle after rvalid with dec_pc 0x1000, dec_inst 0x2402_0005, dec_except 0.
- dec_ready = 0; fetch 4 sequential PCs (0x1000 to 0x100C) with DEPTH 4 -> count reaches 4 and fetch_ready stays 0. Then assert dec_ready -> entries drain in order 0x1000, 0x1004, 0x1008, 0x100C, and fetch_ready returns once count < 4.
- PC 0x1002 with MMU flags clear -> no bus_req; entry enqueued with dec_except = 3'b100 and inst 0. Separately, PC 0x2000 with fetch_miss = 1 -> dec_except = 3'b001.
- Flush one cycle after bus_gnt, with rvalid 3 cycles later -> data dropped; dec_valid stays 0; state returns to IDLE; the next PC 0x3000 is fetched normally.
- Flush in WAIT_GNT with grant delayed 5 cycles -> bus_req held until bus_gnt; the following rvalid is discarded; count stays 0.
- Queue holding 2 entries, rst asserted during WAIT_DATA -> count 0, bus_req 0 and dec_valid 0 the next cycle; a late rvalid is ignored.
